// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - state encoding and default widths for mem_access_ctrl
// Write forwarding is built in when MEM_ACCESS_CTRL_WR_FWD_EN is defined.
package mem_access_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    CAPT  = ST_CAPT,
    ERR   = ST_ERR
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - RAM-side strobe/address/data bus of mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_access_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_access_pkg::DEF_DATA_W
) ();

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-word RAM access controller between MAR/MDR and a sync RAM
// Optional last-write forwarding: define MEM_ACCESS_CTRL_WR_FWD_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       mar_in,
  input  logic [DATA_W-1:0] mdr_in,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] mdr_out,
  output logic              addr_err,
  mem_access_ctrl_if.master mem
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [3:0]        cnt_q, cnt_d;

  logic hi_bad;
  logic fwd_hit;

  assign hi_bad = |mar_in[31:ADDR_W];

`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
  logic              fv_q, fv_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;
  logic              hit_q, hit_d;

  assign fwd_hit = !we && fv_q && (fa_q == mar_in[ADDR_W-1:0]);
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
    fv_d    = fv_q;
    fa_d    = fa_q;
    fdat_d  = fdat_q;
    hit_d   = hit_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = mar_in[ADDR_W-1:0];
          wdata_d = mdr_in;
          if (hi_bad) begin
            state_d = ERR;
          end else if (fwd_hit) begin
            state_d = CAPT;
          end else begin
            state_d = ISSUE;
            rd_d    = !we;
            wr_d    = we;
          end
`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
          hit_d = fwd_hit && !hi_bad;
          if (we && !hi_bad) begin
            fv_d   = 1'b1;
            fa_d   = mar_in[ADDR_W-1:0];
            fdat_d = mdr_in;
          end
`endif
        end
      end
      ISSUE: begin
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end else begin
          state_d = CAPT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = CAPT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPT: begin
        // RAM data_out is valid here: it was read on the edge that closed ISSUE.
        if (!we_q) begin
`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
          mdr_d = hit_q ? fdat_q : mem.mem_rdata;
`else
          mdr_d = mem.mem_rdata;
`endif
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mdr_q   <= '0;
      cnt_q   <= 4'd0;
`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fdat_q  <= '0;
      hit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ACCESS_CTRL_WR_FWD_EN
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fdat_q  <= fdat_d;
      hit_q   <= hit_d;
`endif
    end
  end

  assign ready         = (state_q == IDLE);
  assign done          = done_q;
  assign addr_err      = err_q;
  assign mdr_out       = mdr_q;
  assign mem.mem_read  = rd_q;
  assign mem.mem_write = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
